ehgu_synqzx: RTL and testbench

EHGU_SYNQZX -- requirements
Module: ehgu_synqzx

---
 rtl/ehgu_synqzx.sv | 77 +++++++
 tb/tb_ehgu_synqzx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ehgu_synqzx.sv
// Per-bit multi-flop synchronizer for independent asynchronous inputs.
// Simulation builds add a bounded random input jitter ahead of the first flop.
module ehgu_synqzx #(
   parameter type T         = time,
   parameter T    MAX_DELAY = 1000ps,
   parameter int  STAGES    = 2,
   parameter int  WIDTH     = 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] d_presync,
   output logic [WIDTH-1:0] d_sync
);
   timeunit 1ps;
   timeprecision 1ps;

   if (STAGES < 2) begin : g_bad_stages
      $fatal(1, "ehgu_synqzx: STAGES must be at least 2");
   end
   if (WIDTH < 1) begin : g_bad_width
      $fatal(1, "ehgu_synqzx: WIDTH must be at least 1");
   end
   if ($signed(MAX_DELAY) < 0) begin : g_bad_delay
      $fatal(1, "ehgu_synqzx: MAX_DELAY must not be negative");
   end

   logic [WIDTH-1:0] d_jittered;

`ifdef SYNTHESIS
   assign d_jittered = d_presync;
`else
   // Each bit queues its edges with a random lag; delivery times are clamped
   // to be non-decreasing so edges land in order and the bit settles within
   // MAX_DELAY of its most recent change.
   for (genvar i = 0; i < WIDTH; i++) begin : g_jit
      logic jit_q;
      logic val_q [$];
      T     due_q [$];
      T     last_due;
      T     due;
      event push_ev;

      always @(d_presync[i]) begin
         due = T'($time) + T'($urandom_range(32'(MAX_DELAY), 32'd0));
         if (due < last_due) due = last_due;
         last_due = due;
         val_q.push_back(d_presync[i]);
         due_q.push_back(due);
         -> push_ev;
      end

      always begin
         while (val_q.size() == 0) @(push_ev);
         if (due_q[0] > T'($time)) #(due_q[0] - T'($time));
         jit_q = val_q.pop_front();
         void'(due_q.pop_front());
      end

      assign d_jittered[i] = jit_q;
   end
`endif

   // Stage 0 is the metastability-catching flop; all stages stay adjacent.
   (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [STAGES];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int s = 0; s < STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= d_jittered;
         for (int s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign d_sync = sync_q[STAGES-1];

endmodule

// File: tb/tb_ehgu_synqzx.sv
// Directed bench for ehgu_synqzx: reset, latency, jitter settling, mid-run reset,
// and a three-stage single-bit instance.
module tb_ehgu_synqzx;
   timeunit 1ns;
   timeprecision 1ps;

   logic       clk;
   logic       rstn;
   logic [3:0] d_presync;
   logic [3:0] d_sync;
   logic       d3;
   logic       s3;

   int n_checks = 0;
   int n_fail   = 0;

   ehgu_synqzx #(.STAGES(2), .WIDTH(4)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .d_presync (d_presync),
      .d_sync    (d_sync)
   );

   ehgu_synqzx #(.STAGES(3), .WIDTH(1)) dut3 (
      .clk       (clk),
      .rstn      (rstn),
      .d_presync (d3),
      .d_sync    (s3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rstn = 1'b0;
      d_presync = 4'b0000;
      d3 = 1'b0;
      #1 d_presync = 4'b1010;
      #3;
      n_checks++;
      if (d_sync !== 4'b0000) begin
         n_fail++; $display("FAIL reset_early: got %b expected 0000", d_sync);
      end
      @(posedge clk); #1;
      n_checks++;
      if (d_sync !== 4'b0000) begin
         n_fail++; $display("FAIL reset_clocked: got %b expected 0000", d_sync);
      end
      n_checks++;
      if (dut.d_jittered !== 4'b1010) begin
         n_fail++; $display("FAIL jitter_in_reset: got %b expected 1010", dut.d_jittered);
      end
      n_checks++;
      if (s3 !== 1'b0) begin
         n_fail++; $display("FAIL reset_s3: got %b expected 0", s3);
      end
      #3.4 rstn = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (d_sync !== 4'b0000) begin
         n_fail++; $display("FAIL reset_first_edge: got %b expected 0000", d_sync);
      end
      @(posedge clk); #1;
      n_checks++;
      if (d_sync !== 4'b1010) begin
         n_fail++; $display("FAIL reset_release: got %b expected 1010", d_sync);
      end
   endtask

   task automatic test_latency();
      d_presync = 4'b0110;
      @(posedge clk); #1;
      n_checks++;
      if (d_sync !== 4'b1010) begin
         n_fail++; $display("FAIL latency_edge1: got %b expected 1010", d_sync);
      end
      @(posedge clk); #1;
      n_checks++;
      if (d_sync !== 4'b0110) begin
         n_fail++; $display("FAIL latency_edge2: got %b expected 0110", d_sync);
      end
   endtask

   task automatic test_jitter();
      logic [3:0] vals [6] = '{4'b1001, 4'b0110, 4'b1111, 4'b0000, 4'b0101, 4'b1010};
      for (int k = 0; k < 6; k++) begin
         d_presync = vals[k];
         #1.001;
         n_checks++;
         if (dut.d_jittered !== vals[k]) begin
            n_fail++;
            $display("FAIL jitter_settle[%0d]: got %b expected %b", k, dut.d_jittered, vals[k]);
         end
         #0.5;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic [3:0] v;
      logic [3:0] prev;
      int         local_fail;
      local_fail = 0;
      prev = d_presync;
      for (int k = 0; k < 4; k++) begin
         v = 4'($urandom());
         if (v == prev) v = ~v;
         d_presync = v;
         repeat (3) @(posedge clk);
         #1;
         n_checks++;
         if (d_sync !== v) begin
            n_fail++; local_fail++;
            $display("FAIL random[%0d]: got %b expected %b", k, d_sync, v);
         end
         prev = v;
      end
      if (local_fail == 0) $display("All Vectors passed");
   endtask

   task automatic test_mid_reset();
      d_presync = 4'b0101;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (d_sync !== 4'b0101) begin
         n_fail++; $display("FAIL mid_pre: got %b expected 0101", d_sync);
      end
      d_presync = 4'b1111;
      @(posedge clk); #1;
      n_checks++;
      if (d_sync !== 4'b0101) begin
         n_fail++; $display("FAIL mid_inflight: got %b expected 0101", d_sync);
      end
      rstn = 1'b0;
      #0.5;
      n_checks++;
      if (d_sync !== 4'b0000) begin
         n_fail++; $display("FAIL mid_async_clear: got %b expected 0000", d_sync);
      end
      @(posedge clk); #1;
      n_checks++;
      if (d_sync !== 4'b0000) begin
         n_fail++; $display("FAIL mid_held: got %b expected 0000", d_sync);
      end
      rstn = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (d_sync !== 4'b0000) begin
         n_fail++; $display("FAIL mid_rel_edge1: got %b expected 0000", d_sync);
      end
      @(posedge clk); #1;
      n_checks++;
      if (d_sync !== 4'b1111) begin
         n_fail++; $display("FAIL mid_rel_edge2: got %b expected 1111", d_sync);
      end
   endtask

   task automatic test_stable();
      for (int k = 0; k < 20; k++) begin
         #1;
         n_checks++;
         if (d_sync !== 4'b1111) begin
            n_fail++; $display("FAIL stable[%0d]: got %b expected 1111", k, d_sync);
         end
      end
   endtask

   task automatic test_stages3();
      logic [1:0] exp_seq [2][3] = '{'{2'd0, 2'd0, 2'd1}, '{2'd1, 2'd1, 2'd0}};
      @(posedge clk); #1;
      for (int t = 0; t < 2; t++) begin
         d3 = (t == 0);
         for (int e = 0; e < 3; e++) begin
            @(posedge clk); #1;
            n_checks++;
            if (s3 !== exp_seq[t][e][0]) begin
               n_fail++;
               $display("FAIL stages3[%0d][%0d]: got %b expected %b", t, e, s3, exp_seq[t][e][0]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_jitter();
      test_random();
      test_mid_reset();
      test_stable();
      test_stages3();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
